// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the single-port memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_e;

  typedef enum logic {
    GNT_I,
    GNT_D
  } arb_gnt_e;

  // Word accesses only: any set low address bit means the access is rejected.
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch port, data port and unified memory bus of the arbiter.
interface mem_arbiter_if;
  import mem_arb_pkg::*;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ready;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;
  logic              d_err;

  logic [ADDR_W-1:0] mem_A;
  logic [DATA_W-1:0] mem_WD;
  logic              mem_WE;
  logic [DATA_W-1:0] mem_RD;

  logic              busy;

  // Arbiter view: serves the requesters and drives the memory.
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_RD,
    output i_rdata, i_ready, d_rdata, d_ready, d_err, mem_A, mem_WD, mem_WE, busy
  );

  // Environment view: requesters plus the memory itself.
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_RD,
    input  i_rdata, i_ready, d_rdata, d_ready, d_err, mem_A, mem_WD, mem_WE, busy
  );

endinterface

// File: rtl/arb_wait_counter.sv
// Loadable down-counter that times the wait states of one memory access.
module arb_wait_counter
  import mem_arb_pkg::*;
(
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_done
);

  logic [CNT_W-1:0] r_count;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch and data requests onto one memory with programmable wait
// states; data wins ties unless fetch has been passed over MAX_D_STREAK times.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WAIT_CYCLES  = 1,
  parameter int MAX_D_STREAK = 4
) (
  input  logic          CLK,
  input  logic          RST_N,
  mem_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] WAIT_LD    = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_D_STREAK);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  arb_gnt_e          r_gnt;
  arb_gnt_e          w_gnt;

  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;
  logic              r_misalign;
  logic [CNT_W-1:0]  r_streak;

  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_i_ready;
  logic              r_d_ready;
  logic              r_d_err;

  logic              w_cnt_load;
  logic              w_cnt_dec;
  logic              w_cnt_done;
  logic              w_final;
  logic              w_in_access;

  arb_wait_counter u_wait (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .i_load     (w_cnt_load),
    .i_load_val (WAIT_LD),
    .i_dec      (w_cnt_dec),
    .o_done     (w_cnt_done)
  );

  always_comb begin
    w_gnt = GNT_D;
    if (bus.i_req && bus.d_req) begin
      w_gnt = (r_streak == STREAK_MAX) ? GNT_I : GNT_D;
    end else if (bus.i_req) begin
      w_gnt = GNT_I;
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_load  = 1'b0;
    w_cnt_dec   = 1'b0;
    w_final     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          w_state_nxt = ACCESS;
          w_cnt_load  = 1'b1;
        end
      end
      ACCESS: begin
        w_cnt_dec = 1'b1;
        if (w_cnt_done) begin
          w_final     = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state    <= IDLE;
      r_gnt      <= GNT_I;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_misalign <= 1'b0;
      r_streak   <= '0;
      r_i_rdata  <= '0;
      r_d_rdata  <= '0;
      r_i_ready  <= 1'b0;
      r_d_ready  <= 1'b0;
      r_d_err    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
      r_d_err   <= 1'b0;

      if (w_cnt_load) begin
        r_gnt <= w_gnt;
        if (w_gnt == GNT_D) begin
          r_addr     <= bus.d_addr;
          r_wdata    <= bus.d_wdata;
          r_we       <= bus.d_we;
          r_misalign <= is_misaligned(bus.d_addr[1:0]);
          // Only data grants that jump a waiting fetch count toward starvation.
          if (bus.i_req && (r_streak != STREAK_MAX)) begin
            r_streak <= r_streak + 1'b1;
          end
        end else begin
          r_addr     <= bus.i_addr;
          r_wdata    <= '0;
          r_we       <= 1'b0;
          r_misalign <= 1'b0;
          r_streak   <= '0;
        end
      end

      if (w_final) begin
        if (r_gnt == GNT_D) begin
          r_d_ready <= 1'b1;
          r_d_err   <= r_misalign;
          r_d_rdata <= r_misalign ? '0 : bus.mem_RD;
        end else begin
          r_i_ready <= 1'b1;
          r_i_rdata <= bus.mem_RD;
        end
      end
    end
  end

  assign w_in_access = (r_state == ACCESS);

  assign bus.mem_A   = w_in_access ? r_addr  : '0;
  assign bus.mem_WD  = w_in_access ? r_wdata : '0;
  // Gated with reset so a store cannot land on the edge that abandons it.
  assign bus.mem_WE  = w_final && (r_gnt == GNT_D) && r_we && !r_misalign && RST_N;

  assign bus.i_rdata = r_i_rdata;
  assign bus.i_ready = r_i_ready;
  assign bus.d_rdata = r_d_rdata;
  assign bus.d_ready = r_d_ready;
  assign bus.d_err   = r_d_err;
  assign bus.busy    = (r_state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with one wait state, one with none.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  mem_arbiter_if bus_a ();
  mem_arbiter_if bus_b ();

  mem_arbiter #(.WAIT_CYCLES(1), .MAX_D_STREAK(4)) dut_a (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus_a)
  );

  mem_arbiter #(.WAIT_CYCLES(0), .MAX_D_STREAK(4)) dut_b (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus_b)
  );

  // Word memories indexed by address bits [11:2]; preload shares the write port.
  logic [31:0] mem_a [0:1023];
  logic [31:0] mem_b [0:1023];
  logic        pl_en  = 1'b0;
  logic        pl_sel = 1'b0;
  logic [9:0]  pl_idx = '0;
  logic [31:0] pl_dat = '0;

  assign bus_a.mem_RD = mem_a[bus_a.mem_A[11:2]];
  assign bus_b.mem_RD = mem_b[bus_b.mem_A[11:2]];

  always @(posedge clk) begin
    if (pl_en && !pl_sel) mem_a[pl_idx] <= pl_dat;
    else if (bus_a.mem_WE) mem_a[bus_a.mem_A[11:2]] <= bus_a.mem_WD;
    if (pl_en && pl_sel) mem_b[pl_idx] <= pl_dat;
    else if (bus_b.mem_WE) mem_b[bus_b.mem_A[11:2]] <= bus_b.mem_WD;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic sel, input logic [9:0] idx, input logic [31:0] dat);
    pl_en  = 1'b1;
    pl_sel = sel;
    pl_idx = idx;
    pl_dat = dat;
    tick();
    pl_en  = 1'b0;
  endtask

  // Runs one data access on dut_a; lat is the number of edges to d_ready (0 = timeout).
  task automatic d_access_a(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            output int lat, output logic [31:0] rdata, output logic err,
                            output int we_cnt, output logic [31:0] we_addr,
                            output logic [31:0] we_data, output logic saw_i_ready);
    lat         = 0;
    we_cnt      = 0;
    we_addr     = '0;
    we_data     = '0;
    rdata       = '0;
    err         = 1'b0;
    saw_i_ready = 1'b0;
    bus_a.d_req   = 1'b1;
    bus_a.d_we    = we;
    bus_a.d_addr  = addr;
    bus_a.d_wdata = wdata;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus_a.mem_WE) begin
        we_cnt++;
        we_addr = bus_a.mem_A;
        we_data = bus_a.mem_WD;
      end
      if (bus_a.i_ready) saw_i_ready = 1'b1;
      if (bus_a.d_ready) begin
        lat   = k;
        rdata = bus_a.d_rdata;
        err   = bus_a.d_err;
        break;
      end
    end
    bus_a.d_req = 1'b0;
  endtask

  task automatic test_reset();
    bus_a.i_req = 1'b0; bus_a.i_addr = '0; bus_a.d_req = 1'b0;
    bus_a.d_we  = 1'b0; bus_a.d_addr = '0; bus_a.d_wdata = '0;
    bus_b.i_req = 1'b0; bus_b.i_addr = '0; bus_b.d_req = 1'b0;
    bus_b.d_we  = 1'b0; bus_b.d_addr = '0; bus_b.d_wdata = '0;
    rst_n = 1'b0;
    tick();
    tick();
    preload(1'b0, 10'h101, 32'hDEAD_BEEF);
    preload(1'b0, 10'h102, 32'h1111_1111);
    preload(1'b0, 10'h004, 32'hAAAA_0010);
    preload(1'b0, 10'h008, 32'hBBBB_0020);
    preload(1'b0, 10'h3FF, 32'h0000_0000);
    preload(1'b1, 10'h000, 32'h1000_0000);
    preload(1'b1, 10'h001, 32'h2000_0004);
    preload(1'b1, 10'h002, 32'h3000_0008);
    total++;
    if ({bus_a.i_rdata, bus_a.d_rdata, bus_a.mem_A, bus_a.mem_WD} !== 128'h0) begin
      bad++;
      $display("FAIL reset_words_a: got %h want 0",
               {bus_a.i_rdata, bus_a.d_rdata, bus_a.mem_A, bus_a.mem_WD});
    end
    total++;
    if ({bus_a.i_ready, bus_a.d_ready, bus_a.d_err, bus_a.mem_WE, bus_a.busy} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags_a: got %b want 00000",
               {bus_a.i_ready, bus_a.d_ready, bus_a.d_err, bus_a.mem_WE, bus_a.busy});
    end
    total++;
    if ({bus_b.i_ready, bus_b.d_ready, bus_b.busy, bus_b.i_rdata} !== 35'h0) begin
      bad++;
      $display("FAIL reset_b: got %h want 0",
               {bus_b.i_ready, bus_b.d_ready, bus_b.busy, bus_b.i_rdata});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_load();
    int lat, wc; logic [31:0] rd, wa, wd; logic er, si;
    d_access_a(1'b0, 32'h0000_0404, 32'h0, lat, rd, er, wc, wa, wd, si);
    total++;
    if (lat !== 3) begin bad++; $display("FAIL load_latency: got %0d want 3", lat); end
    total++;
    if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL load_rdata: got %h want deadbeef", rd); end
    total++;
    if ({er, si, wc[0]} !== 3'b000) begin
      bad++; $display("FAIL load_side_effects: got err=%b i_ready=%b we=%0d want 0 0 0", er, si, wc);
    end
    tick();
    total++;
    if ({bus_a.d_ready, bus_a.busy} !== 2'b00) begin
      bad++; $display("FAIL load_pulse: got ready/busy=%b want 00", {bus_a.d_ready, bus_a.busy});
    end
  endtask

  task automatic test_store_load();
    int lat, wc; logic [31:0] rd, wa, wd; logic er, si;
    d_access_a(1'b1, 32'h7FFF_FFFC, 32'h1234_5678, lat, rd, er, wc, wa, wd, si);
    total++;
    if (lat !== 3 || er !== 1'b0) begin
      bad++; $display("FAIL store_done: got lat=%0d err=%b want 3 0", lat, er);
    end
    total++;
    if (wc !== 1) begin bad++; $display("FAIL store_we_count: got %0d want 1", wc); end
    total++;
    if (wa !== 32'h7FFF_FFFC || wd !== 32'h1234_5678) begin
      bad++; $display("FAIL store_bus: got A=%h WD=%h want 7ffffffc 12345678", wa, wd);
    end
    tick();
    total++;
    if (mem_a[10'h3FF] !== 32'h1234_5678) begin
      bad++; $display("FAIL store_mem: got %h want 12345678", mem_a[10'h3FF]);
    end
    d_access_a(1'b0, 32'h7FFF_FFFC, 32'h0, lat, rd, er, wc, wa, wd, si);
    total++;
    if (rd !== 32'h1234_5678 || wc !== 0) begin
      bad++; $display("FAIL reload_rdata: got %h we=%0d want 12345678 0", rd, wc);
    end
    tick();
  endtask

  task automatic test_streak();
    logic [9:0] exp_is_d;
    int g;
    exp_is_d = 10'b01111_01111;
    g = 0;
    bus_a.i_req  = 1'b1; bus_a.i_addr = 32'h0000_0010;
    bus_a.d_req  = 1'b1; bus_a.d_we   = 1'b0; bus_a.d_addr = 32'h0000_0020;
    for (int k = 0; k < 200 && g < 10; k++) begin
      tick();
      if (bus_a.d_ready || bus_a.i_ready) begin
        total++;
        if (bus_a.d_ready !== exp_is_d[g] || bus_a.i_ready !== !exp_is_d[g]) begin
          bad++;
          $display("FAIL streak_order[%0d]: got d=%b i=%b want d=%b", g,
                   bus_a.d_ready, bus_a.i_ready, exp_is_d[g]);
        end else if (bus_a.d_ready && bus_a.d_rdata !== 32'hBBBB_0020) begin
          bad++; $display("FAIL streak_drdata[%0d]: got %h want bbbb0020", g, bus_a.d_rdata);
        end else if (bus_a.i_ready && bus_a.i_rdata !== 32'hAAAA_0010) begin
          bad++; $display("FAIL streak_irdata[%0d]: got %h want aaaa0010", g, bus_a.i_rdata);
        end
        g++;
        if (g == 10) begin
          bus_a.i_req = 1'b0;
          bus_a.d_req = 1'b0;
        end
      end
    end
    bus_a.i_req = 1'b0;
    bus_a.d_req = 1'b0;
    total++;
    if (g !== 10) begin bad++; $display("FAIL streak_timeout: got %0d grants want 10", g); end
    tick();
  endtask

  task automatic test_misaligned();
    int lat, wc; logic [31:0] rd, wa, wd; logic er, si;
    d_access_a(1'b1, 32'h0000_0406, 32'h5555_5555, lat, rd, er, wc, wa, wd, si);
    total++;
    if (lat !== 3 || er !== 1'b1) begin
      bad++; $display("FAIL misalign_err: got lat=%0d err=%b want 3 1", lat, er);
    end
    total++;
    if (rd !== 32'h0 || wc !== 0) begin
      bad++; $display("FAIL misalign_nowrite: got rdata=%h we=%0d want 0 0", rd, wc);
    end
    tick();
    total++;
    if (mem_a[10'h101] !== 32'hDEAD_BEEF || bus_a.d_err !== 1'b0) begin
      bad++; $display("FAIL misalign_mem: got %h err=%b want deadbeef 0", mem_a[10'h101], bus_a.d_err);
    end
  endtask

  task automatic test_reset_mid_store();
    logic saw_ready;
    bus_a.d_req = 1'b1; bus_a.d_we = 1'b1;
    bus_a.d_addr = 32'h0000_0408; bus_a.d_wdata = 32'hCAFE_F00D;
    tick();
    tick();
    total++;
    if (bus_a.mem_WE !== 1'b1) begin
      bad++; $display("FAIL midrst_final_we: got %b want 1", bus_a.mem_WE);
    end
    rst_n = 1'b0;
    bus_a.d_req = 1'b0;
    #1;
    total++;
    if (bus_a.mem_WE !== 1'b0) begin
      bad++; $display("FAIL midrst_we_gate: got %b want 0", bus_a.mem_WE);
    end
    tick();
    total++;
    if ({bus_a.d_ready, bus_a.d_err, bus_a.busy, bus_a.mem_WE, bus_a.mem_A, bus_a.mem_WD,
         bus_a.d_rdata, bus_a.i_rdata} !== 132'h0) begin
      bad++;
      $display("FAIL midrst_outputs: got rdy=%b busy=%b A=%h drd=%h want all 0",
               bus_a.d_ready, bus_a.busy, bus_a.mem_A, bus_a.d_rdata);
    end
    total++;
    if (mem_a[10'h102] !== 32'h1111_1111) begin
      bad++; $display("FAIL midrst_mem: got %h want 11111111", mem_a[10'h102]);
    end
    rst_n = 1'b1;
    saw_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus_a.d_ready || bus_a.busy) saw_ready = 1'b1;
    end
    total++;
    if (saw_ready !== 1'b0) begin bad++; $display("FAIL midrst_no_ready: got 1 want 0"); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [3];
    logic [31:0] addrs [3];
    int lat;
    words[0] = 32'h1000_0000; words[1] = 32'h2000_0004; words[2] = 32'h3000_0008;
    addrs[0] = 32'h0;         addrs[1] = 32'h4;         addrs[2] = 32'h8;
    bus_b.i_req  = 1'b1;
    bus_b.i_addr = addrs[0];
    for (int n = 0; n < 3; n++) begin
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
        tick();
        if (bus_b.i_ready) begin lat = k; break; end
      end
      total++;
      if (lat !== ((n == 0) ? 2 : 3)) begin
        bad++; $display("FAIL b2b_spacing[%0d]: got %0d want %0d", n, lat, (n == 0) ? 2 : 3);
      end
      total++;
      if (bus_b.i_rdata !== words[n]) begin
        bad++; $display("FAIL b2b_rdata[%0d]: got %h want %h", n, bus_b.i_rdata, words[n]);
      end
      if (n < 2) bus_b.i_addr = addrs[n + 1];
      else       bus_b.i_req  = 1'b0;
    end
    tick();
    total++;
    if ({bus_b.i_ready, bus_b.busy, bus_b.d_ready} !== 3'b000) begin
      bad++; $display("FAIL b2b_idle: got %b want 000", {bus_b.i_ready, bus_b.busy, bus_b.d_ready});
    end
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_store_load();
    test_streak();
    test_misaligned();
    test_reset_mid_store();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
